lc3b_control: RTL

Microsequencer for the single-bus LC-3b datapath. Fetches, decodes and executes one instruction at a time by driving the datapath load enables, ALU op and mux selects, using the IR, the N/Z/P condition flags and the memory ready flag R. The block also provides a memory-wait watchdog and a retired-instruction counter. It instantiates nothing in the datapath; the top level wires it to the datapath ports of the same name.

---
 rtl/lc3b_pkg.sv | 47 ++++
 rtl/lc3b_control_mem_watchdog.sv | 32 +++
 rtl/lc3b_control.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b microsequencer: state encoding,
// opcode values, ALU operation codes and fault codes.
package lc3b_pkg;

    typedef enum logic [3:0] {
        F_MAR,
        F_MEM,
        F_IR,
        DECODE,
        EX_ALU,
        BR,
        M_MAR,
        M_RD,
        M_WB,
        M_WR,
        HALT
    } state_t;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_LDW  = 4'h6;
    localparam logic [3:0] OP_STW  = 4'h7;
    localparam logic [3:0] OP_TRAP = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b011;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
    localparam logic [1:0] FAULT_TRAP    = 2'b11;

    // Only the three ALU opcodes reach EX_ALU; anything else falls back to PASS_A.
    function automatic logic [2:0] alu_for(input logic [3:0] op);
        case (op)
            OP_ADD:  alu_for = ALU_ADD;
            OP_AND:  alu_for = ALU_AND;
            OP_XOR:  alu_for = ALU_XOR;
            default: alu_for = ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/lc3b_control_mem_watchdog.sv
// Memory-wait watchdog: counts cycles with R low while the sequencer waits on
// memory, and flags the cycle on which the wait budget runs out.
module mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic r,
    output logic timeout
);

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt;

    // No wait state follows another directly, so clearing outside the wait
    // states is the same as clearing on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (!waiting) begin
            cnt <= 8'd0;
        end else if (!r) begin
            cnt <= cnt + 8'd1;
        end
    end

    // R high on the final allowed cycle still completes the access.
    assign timeout = waiting && !r && (cnt == LAST_WAIT);

endmodule

// File: rtl/lc3b_control.sv
// Microsequencer for the single-bus LC-3b datapath: fetch, decode, execute,
// with a memory-wait watchdog and a retired-instruction counter.
module lc3b_control
    import lc3b_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        R,
    output logic [2:0]  aluop,
    output logic        LDCC,
    output logic        LDIR,
    output logic        LDREG,
    output logic        LDPC,
    output logic        LDMAR,
    output logic        LDMDR,
    output logic        MEMEN,
    output logic        marmux,
    output logic        regmux,
    output logic        pcmux,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [15:0] retired,
    output state_t      dbg_state
);

    state_t      state, next_state;
    logic [1:0]  fault_q, fault_d;
    logic [15:0] retired_q;
    logic        retire;
    logic        waiting;
    logic        timeout;
    logic [3:0]  opcode;
    logic        taken;

    assign opcode    = IR[15:12];
    assign taken     = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
    assign waiting   = (state == F_MEM) || (state == M_RD) || (state == M_WR);
    assign fault     = fault_q;
    assign retired   = retired_q;
    assign dbg_state = state;

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (reset),
        .waiting (waiting),
        .r       (R),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= F_MAR;
            fault_q   <= FAULT_NONE;
            retired_q <= 16'd0;
        end else begin
            state   <= next_state;
            fault_q <= fault_d;
            if (retire) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        fault_d    = fault_q;
        retire     = 1'b0;
        aluop      = ALU_ADD;
        LDCC       = 1'b0;
        LDIR       = 1'b0;
        LDREG      = 1'b0;
        LDPC       = 1'b0;
        LDMAR      = 1'b0;
        LDMDR      = 1'b0;
        MEMEN      = 1'b0;
        marmux     = 1'b0;
        regmux     = 1'b0;
        pcmux      = 1'b0;
        halted     = 1'b0;

        case (state)
            F_MAR: begin
                LDMAR      = 1'b1;
                next_state = F_MEM;
            end
            F_MEM: begin
                if (R) begin
                    LDMDR      = 1'b1;
                    next_state = F_IR;
                end else if (timeout) begin
                    next_state = HALT;
                    fault_d    = FAULT_TIMEOUT;
                end
            end
            F_IR: begin
                LDIR       = 1'b1;
                LDPC       = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_XOR: next_state = EX_ALU;
                    OP_BR:                  next_state = BR;
                    OP_LDW, OP_STW:         next_state = M_MAR;
                    OP_TRAP: begin
                        next_state = HALT;
                        fault_d    = FAULT_TRAP;
                    end
                    default: begin
                        next_state = HALT;
                        fault_d    = FAULT_ILLEGAL;
                    end
                endcase
            end
            EX_ALU: begin
                aluop      = alu_for(opcode);
                LDREG      = 1'b1;
                LDCC       = 1'b1;
                retire     = 1'b1;
                next_state = F_MAR;
            end
            BR: begin
                LDPC       = taken;
                pcmux      = taken;
                retire     = 1'b1;
                next_state = F_MAR;
            end
            M_MAR: begin
                LDMAR      = 1'b1;
                marmux     = 1'b1;
                next_state = (opcode == OP_STW) ? M_WR : M_RD;
            end
            M_RD: begin
                if (R) begin
                    LDMDR      = 1'b1;
                    next_state = M_WB;
                end else if (timeout) begin
                    next_state = HALT;
                    fault_d    = FAULT_TIMEOUT;
                end
            end
            M_WB: begin
                LDREG      = 1'b1;
                LDCC       = 1'b1;
                regmux     = 1'b1;
                retire     = 1'b1;
                next_state = F_MAR;
            end
            M_WR: begin
                MEMEN = 1'b1;
                if (R) begin
                    retire     = 1'b1;
                    next_state = F_MAR;
                end else if (timeout) begin
                    next_state = HALT;
                    fault_d    = FAULT_TIMEOUT;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: next_state = F_MAR;
        endcase

        // While reset is held the state already reads F_MAR; keep its
        // enables quiet until reset is released.
        if (!reset) begin
            aluop  = ALU_ADD;
            LDCC   = 1'b0;
            LDIR   = 1'b0;
            LDREG  = 1'b0;
            LDPC   = 1'b0;
            LDMAR  = 1'b0;
            LDMDR  = 1'b0;
            MEMEN  = 1'b0;
            marmux = 1'b0;
            regmux = 1'b0;
            pcmux  = 1'b0;
            halted = 1'b0;
        end
    end

endmodule
